// File: rtl/fifo_rd_unload_pkg.sv
// Shared constants for the FIFO read-side unloader: FSM state encodings,
// skid buffer sizing and the pointer-width helper used for configuration checks.
package fifo_rd_unload_pkg;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  localparam int SKID_DEPTH = 2;

  typedef logic [1:0] occ_t;

  function automatic int ptrWidthOf(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_skid2.sv
// Two-entry skid buffer with a registered head; words leave in arrival order.
// A simultaneous push and pop keeps occupancy and shifts the skid entry forward.
module fifo_skid2
  import fifo_rd_unload_pkg::*;
#(
  parameter int FIFOWIDTH = 72
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clr,
  input  logic                 i_push,
  input  logic [FIFOWIDTH-1:0] i_push_data,
  input  logic                 i_pop,
  output occ_t                 o_occ,
  output logic                 o_head_valid,
  output logic [FIFOWIDTH-1:0] o_head_data
);

  occ_t                 r_occ;
  logic [FIFOWIDTH-1:0] r_head;
  logic [FIFOWIDTH-1:0] r_skid;

  // The caller never pushes into a full buffer without also popping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_occ  <= '0;
      r_head <= '0;
      r_skid <= '0;
    end else if (i_clr) begin
      r_occ <= '0;
    end else begin
      case (r_occ)
        2'd0: begin
          if (i_push) begin
            r_head <= i_push_data;
            r_occ  <= 2'd1;
          end
        end
        2'd1: begin
          if (i_push && i_pop) begin
            r_head <= i_push_data;
          end else if (i_push) begin
            r_skid <= i_push_data;
            r_occ  <= 2'd2;
          end else if (i_pop) begin
            r_occ <= 2'd0;
          end
        end
        default: begin
          if (i_pop) begin
            r_head <= r_skid;
            if (i_push) begin
              r_skid <= i_push_data;
            end else begin
              r_occ <= 2'd1;
            end
          end
        end
      endcase
    end
  end

  assign o_occ        = r_occ;
  assign o_head_valid = (r_occ != 2'd0);
  assign o_head_data  = r_head;

endmodule

// File: rtl/fifo_rd_unload.sv
// Read-side unloader: pops the async FIFO into a 2-entry skid buffer and streams words out.
// Optional flush support is compiled in with FIFO_RD_FLUSH_EN.
module fifo_rd_unload
  import fifo_rd_unload_pkg::*;
#(
  parameter int FIFODEPTH    = 16,
  parameter int FIFOWIDTH    = 72,
  parameter int FIFOPTRWIDTH = 4
) (
  input  logic                  clk_rd,
  input  logic                  rst_rd_n,
  input  logic [FIFOPTRWIDTH:0] numfilled,
  input  logic [FIFOWIDTH-1:0]  rdata,
  input  logic                  underflow,
  output logic                  rstb,
  input  logic                  rd_en,
  output logic                  out_valid,
  output logic [FIFOWIDTH-1:0]  out_data,
  input  logic                  out_ready,
  input  logic                  err_clr,
  output logic                  underflow_err
`ifdef FIFO_RD_FLUSH_EN
  ,
  input  logic                  flush,
  output logic                  flush_busy
`endif
);

  if (ptrWidthOf(FIFODEPTH) != FIFOPTRWIDTH) begin : g_cfg_check
    $error("fifo_rd_unload: FIFOPTRWIDTH must equal log2(FIFODEPTH)");
  end

  occ_t                 w_occ;
  logic                 w_head_valid;
  logic [FIFOWIDTH-1:0] w_head_data;
  logic                 r_inflight;
  logic                 r_underflow_err;
  logic                 w_accept;
  logic [2:0]           w_committed;
  logic                 w_room;
  logic                 w_has_data;
  logic                 w_run_pop;
  logic                 w_push;
  logic                 w_clr;

  assign w_accept    = w_head_valid & out_ready;
  assign w_has_data  = (numfilled != '0);
  // Words already owned by the buffer, net of the one leaving this cycle, must stay below two.
  assign w_committed = {1'b0, w_occ} + {2'b00, r_inflight};
  assign w_room      = (w_committed < (3'(SKID_DEPTH) + {2'b00, w_accept}));
  assign w_run_pop   = rd_en & w_has_data & w_room;

`ifdef FIFO_RD_FLUSH_EN
  logic [0:0] r_state;
  logic       w_in_flush;

  assign w_in_flush = (r_state == ST_FLUSH);
  assign w_clr      = ~w_in_flush & flush;
  assign w_push     = r_inflight & ~w_in_flush;
  assign rstb       = rst_rd_n & (w_in_flush ? w_has_data : w_run_pop);
  assign flush_busy = w_in_flush;

  // Stay in FLUSH until the FIFO is empty, the last pop has returned and flush is released.
  always_ff @(posedge clk_rd) begin
    if (!rst_rd_n) begin
      r_state <= ST_RUN;
    end else if (r_state == ST_RUN) begin
      if (flush) begin
        r_state <= ST_FLUSH;
      end
    end else if (!w_has_data && !r_inflight && !flush) begin
      r_state <= ST_RUN;
    end
  end
`else
  assign w_clr  = 1'b0;
  assign w_push = r_inflight;
  assign rstb   = rst_rd_n & w_run_pop;
`endif

  always_ff @(posedge clk_rd) begin
    if (!rst_rd_n) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= rstb;
    end
  end

  always_ff @(posedge clk_rd) begin
    if (!rst_rd_n) begin
      r_underflow_err <= 1'b0;
    end else if (underflow) begin
      r_underflow_err <= 1'b1;
    end else if (err_clr) begin
      r_underflow_err <= 1'b0;
    end
  end

  fifo_skid2 #(
    .FIFOWIDTH(FIFOWIDTH)
  ) u_skid (
    .clk         (clk_rd),
    .rst_n       (rst_rd_n),
    .i_clr       (w_clr),
    .i_push      (w_push),
    .i_push_data (rdata),
    .i_pop       (w_accept),
    .o_occ       (w_occ),
    .o_head_valid(w_head_valid),
    .o_head_data (w_head_data)
  );

  assign out_valid     = w_head_valid;
  assign out_data      = w_head_data;
  assign underflow_err = r_underflow_err;

endmodule

// File: tb/tb_fifo_rd_unload.sv
// Directed bench for fifo_rd_unload: a FIFO model feeds the DUT and a scoreboard
// queue holds the words expected on the stream, checked when each one is accepted.
module tb_fifo_rd_unload;

  localparam int W  = 72;
  localparam int PW = 4;

  logic          clk_rd = 1'b0;
  logic          rst_rd_n;
  logic [PW:0]   numfilled;
  logic [W-1:0]  rdata;
  logic          underflow;
  logic          rstb;
  logic          rd_en;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
  logic          err_clr;
  logic          underflow_err;
`ifdef FIFO_RD_FLUSH_EN
  logic          flush;
  logic          flush_busy;
`endif

  always #5 clk_rd = ~clk_rd;

  fifo_rd_unload #(
    .FIFODEPTH   (16),
    .FIFOWIDTH   (W),
    .FIFOPTRWIDTH(PW)
  ) dut (
    .clk_rd       (clk_rd),
    .rst_rd_n     (rst_rd_n),
    .numfilled    (numfilled),
    .rdata        (rdata),
    .underflow    (underflow),
    .rstb         (rstb),
    .rd_en        (rd_en),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .err_clr      (err_clr),
    .underflow_err(underflow_err)
`ifdef FIFO_RD_FLUSH_EN
    ,
    .flush        (flush),
    .flush_busy   (flush_busy)
`endif
  );

  logic [W-1:0] fifoQ[$];
  logic [W-1:0] expQ[$];
  int compared   = 0;
  int mismatched = 0;
  int popCount;
  int rstbCycles;
  int validCycles;
  logic rstbNow;
  logic validNow;

  task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic loadWords(input int n, input logic [W-1:0] base);
    for (int i = 0; i < n; i++) begin
      fifoQ.push_back(base + W'(i));
      expQ.push_back(base + W'(i));
    end
    numfilled = (PW+1)'(fifoQ.size());
  endtask

  // One read-clock cycle: called at a falling edge with inputs already driven.
  task automatic applyStimulus();
    logic [W-1:0] expWord;
    numfilled = (PW+1)'(fifoQ.size());
    #1;
    rstbNow  = rstb;
    validNow = out_valid;
    if (rstbNow) begin
      rstbCycles++;
      checkOutput("pop_nonempty", W'(fifoQ.size() != 0), W'(1));
    end
    if (validNow === 1'b1) validCycles++;
    if (out_valid === 1'b1 && out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_word", W'(expQ.size()), W'(1));
      end else begin
        expWord = expQ.pop_front();
        checkOutput("stream_data", out_data, expWord);
      end
    end
    @(posedge clk_rd);
    #1;
    if (rstbNow && fifoQ.size() != 0) begin
      rdata = fifoQ.pop_front();
      popCount++;
    end else begin
      rdata = {9{8'hEE}};
    end
    numfilled = (PW+1)'(fifoQ.size());
    @(negedge clk_rd);
  endtask

  initial begin
    int firstPop;
    int lastPop;
    int firstValid;
    int lastValid;

    rst_rd_n  = 1'b0;
    rd_en     = 1'b0;
    out_ready = 1'b0;
    underflow = 1'b0;
    err_clr   = 1'b0;
    rdata     = '0;
    numfilled = '0;
    popCount  = 0;
    rstbCycles  = 0;
    validCycles = 0;
`ifdef FIFO_RD_FLUSH_EN
    flush = 1'b0;
`endif
    @(negedge clk_rd);
    applyStimulus();
    applyStimulus();
    checkOutput("reset_out_valid", W'(out_valid), W'(0));
    checkOutput("reset_out_data", out_data, W'(0));
    checkOutput("reset_underflow_err", W'(underflow_err), W'(0));
    checkOutput("reset_rstb", W'(rstb), W'(0));
    checkOutput("reset_occ", W'(dut.w_occ), W'(0));
    checkOutput("reset_inflight", W'(dut.r_inflight), W'(0));
`ifdef FIFO_RD_FLUSH_EN
    checkOutput("reset_flush_busy", W'(flush_busy), W'(0));
`endif
    rst_rd_n = 1'b1;

    $display("[TB] streaming 8 words with out_ready held high");
    rstbCycles = 0; validCycles = 0; popCount = 0;
    firstPop = -1; lastPop = -1; firstValid = -1; lastValid = -1;
    out_ready = 1'b1;
    rd_en     = 1'b1;
    loadWords(8, W'(1));
    for (int i = 0; i < 14; i++) begin
      applyStimulus();
      if (rstbNow) begin
        if (firstPop < 0) firstPop = i;
        lastPop = i;
      end
      if (validNow === 1'b1) begin
        if (firstValid < 0) firstValid = i;
        lastValid = i;
      end
    end
    checkOutput("stream_rstb_count", W'(rstbCycles), W'(8));
    checkOutput("stream_rstb_span", W'(lastPop - firstPop + 1), W'(8));
    checkOutput("stream_valid_count", W'(validCycles), W'(8));
    checkOutput("stream_valid_span", W'(lastValid - firstValid + 1), W'(8));
    checkOutput("stream_all_delivered", W'(expQ.size()), W'(0));
    checkOutput("stream_rstb_idle", W'(rstb), W'(0));

    $display("[TB] backpressure with 4 words present");
    out_ready = 1'b0;
    popCount  = 0;
    loadWords(4, W'(1));
    for (int i = 0; i < 5; i++) applyStimulus();
    checkOutput("bp_pop_count", W'(popCount), W'(2));
    checkOutput("bp_occ", W'(dut.w_occ), W'(2));
    checkOutput("bp_out_valid", W'(out_valid), W'(1));
    checkOutput("bp_out_data_held", out_data, W'(1));
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) applyStimulus();
    checkOutput("bp_all_delivered", W'(expQ.size()), W'(0));
    checkOutput("bp_pop_total", W'(popCount), W'(4));

    $display("[TB] empty FIFO and underflow error flag");
    rstbCycles = 0;
    for (int i = 0; i < 10; i++) applyStimulus();
    checkOutput("empty_no_rstb", W'(rstbCycles), W'(0));
    checkOutput("empty_out_valid", W'(out_valid), W'(0));
    checkOutput("empty_err_clear", W'(underflow_err), W'(0));
    underflow = 1'b1;
    applyStimulus();
    checkOutput("err_set", W'(underflow_err), W'(1));
    err_clr = 1'b1;
    applyStimulus();
    checkOutput("err_set_wins", W'(underflow_err), W'(1));
    underflow = 1'b0;
    applyStimulus();
    checkOutput("err_cleared", W'(underflow_err), W'(0));
    err_clr = 1'b0;

    $display("[TB] rd_en gating with 5 words present");
    rd_en    = 1'b0;
    popCount = 0;
    loadWords(5, 72'hA5_0000_0000_0000_0010);
    for (int i = 0; i < 6; i++) applyStimulus();
    checkOutput("gated_no_pop", W'(popCount), W'(0));
    checkOutput("gated_out_valid", W'(out_valid), W'(0));
    rd_en = 1'b1;
    for (int i = 0; i < 12; i++) applyStimulus();
    checkOutput("gated_pop_total", W'(popCount), W'(5));
    checkOutput("gated_all_delivered", W'(expQ.size()), W'(0));
    checkOutput("gated_rstb_idle", W'(rstb), W'(0));

    $display("[TB] reset while a word is in flight");
    out_ready = 1'b0;
    popCount  = 0;
    loadWords(4, 72'h3C_0000_0000_0000_0020);
    underflow = 1'b1;
    applyStimulus();
    applyStimulus();
    underflow = 1'b0;
    checkOutput("pre_reset_occ", W'(dut.w_occ), W'(1));
    checkOutput("pre_reset_inflight", W'(dut.r_inflight), W'(1));
    rst_rd_n = 1'b0;
    applyStimulus();
    checkOutput("midreset_out_valid", W'(out_valid), W'(0));
    checkOutput("midreset_out_data", out_data, W'(0));
    checkOutput("midreset_rstb", W'(rstb), W'(0));
    checkOutput("midreset_occ", W'(dut.w_occ), W'(0));
    checkOutput("midreset_inflight", W'(dut.r_inflight), W'(0));
    checkOutput("midreset_err", W'(underflow_err), W'(0));
    void'(expQ.pop_front());
    void'(expQ.pop_front());
    rst_rd_n  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) applyStimulus();
    checkOutput("postreset_delivered", W'(expQ.size()), W'(0));
    checkOutput("postreset_pop_total", W'(popCount), W'(4));

`ifdef FIFO_RD_FLUSH_EN
    $display("[TB] flush with 2 words buffered");
    begin
      int guard;
      out_ready = 1'b0;
      popCount  = 0;
      loadWords(6, 72'h77_0000_0000_0000_0040);
      for (int i = 0; i < 4; i++) applyStimulus();
      checkOutput("preflush_occ", W'(dut.w_occ), W'(2));
      expQ.delete();
      flush = 1'b1;
      applyStimulus();
      flush = 1'b0;
      checkOutput("flush_out_valid", W'(out_valid), W'(0));
      checkOutput("flush_busy_set", W'(flush_busy), W'(1));
      out_ready = 1'b1;
      guard = 0;
      while (flush_busy === 1'b1 && guard < 30) begin
        applyStimulus();
        guard++;
      end
      checkOutput("flush_done", W'(flush_busy), W'(0));
      checkOutput("flush_pop_total", W'(popCount), W'(6));
      checkOutput("flush_fifo_empty", W'(numfilled), W'(0));
      for (int i = 0; i < 3; i++) applyStimulus();
      checkOutput("flush_no_data", W'(out_valid), W'(0));
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "[TB] timeout");
  end

endmodule
